// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and helpers for the FND scan controller
package fnd_pkg;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] COM_OFF    = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  // 1 when every nibble from digit i upward is zero (leading-zero test).
  function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] i);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(i) && v[4*j +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/decoder_7seg.sv
// rtl/decoder_7seg.sv - hex nibble to active-low 7-segment pattern, dp dark
module decoder_7seg (
  input  logic [3:0] hex_value,
  output logic [7:0] seg_7
);

  always_comb begin
    case (hex_value)
      4'h0: seg_7 = 8'hC0;
      4'h1: seg_7 = 8'hF9;
      4'h2: seg_7 = 8'hA4;
      4'h3: seg_7 = 8'hB0;
      4'h4: seg_7 = 8'h99;
      4'h5: seg_7 = 8'h92;
      4'h6: seg_7 = 8'h82;
      4'h7: seg_7 = 8'hF8;
      4'h8: seg_7 = 8'h80;
      4'h9: seg_7 = 8'h90;
      4'hA: seg_7 = 8'h88;
      4'hB: seg_7 = 8'h83;
      4'hC: seg_7 = 8'hC6;
      4'hD: seg_7 = 8'hA1;
      4'hE: seg_7 = 8'h86;
      default: seg_7 = 8'h8E;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit common-anode FND scan with blanking gap,
// per-digit enable, decimal points and leading-zero blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  output logic [7:0]  seg_7,
  output logic [3:0]  com,
  output logic        frame_tick
);

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_END  = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam logic           SKIP_BLANK = (BLANK_CYC == 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          state_q, state_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick_q, tick_d;

  logic          frame_start;
  logic [15:0]   shadow_eff;
  logic [3:0]    nibble;
  logic [7:0]    dec_seg;
  logic          lit;
  logic          drive;

  decoder_7seg u_dec (
    .hex_value (nibble),
    .seg_7     (dec_seg)
  );

  always_comb begin
    // The frame-start cycle already displays the freshly captured value.
    frame_start = (cnt_q == '0) && (idx_q == 2'd0);
    shadow_eff  = frame_start ? value : shadow_q;
    shadow_d    = shadow_eff;
    nibble      = shadow_eff[{idx_q, 2'b00} +: 4];

    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      idx_d   = idx_q + 2'd1;
      state_d = SKIP_BLANK ? ST_DRIVE : ST_BLANK;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      state_d = (state_q == ST_BLANK && cnt_q == BLANK_END) ? ST_DRIVE : state_q;
    end

    drive = (state_q == ST_DRIVE) || SKIP_BLANK;
    lit   = digit_en[idx_q] &&
            !(lz_blank && idx_q != 2'd0 && upper_zero(shadow_eff, idx_q));

    tick_d = frame_start;
    if (drive && lit) begin
      com_d = ~(4'b0001 << idx_q);
      // Decoder leaves dp dark; pull it low here when requested.
      seg_d = {dec_seg[7] & ~dp_en[idx_q], dec_seg[6:0]};
    end else begin
      com_d = COM_OFF;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      state_q  <= ST_BLANK;
      shadow_q <= 16'h0000;
      com_q    <= COM_OFF;
      seg_q    <= SEG_BLANK;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      com_q    <= com_d;
      seg_q    <= seg_d;
      tick_q   <= tick_d;
    end
  end

  assign com        = com_q;
  assign seg_7      = seg_q;
  assign frame_tick = tick_q;

endmodule
